// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan controller with per-digit blanking, blinking and dead time
module seg_scan_ctrl #(
  parameter int DIV_WIDTH   = 17,
  parameter int DEAD        = 4,
  parameter int BLINK_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
  input  logic [3:0] blink_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_done
);
  localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             sel_q, sel_d;
  logic [DW-1:0]          dead_q, dead_d;
  logic [BLINK_WIDTH-1:0] frame_q, frame_d;
  logic [3:0]             an_q, an_d;
  logic                   done_q, done_d;
  logic                   tick, wrap;
  logic [3:0]             lit;
  always_comb begin
    tick    = en && (cnt_q == '1);
    wrap    = tick && (sel_q == 2'd3);
    lit     = (4'b0001 << sel_q) & digit_en & ~(blink_mask & {4{frame_q[BLINK_WIDTH-1]}});
    cnt_d   = en ? cnt_q + 1'b1 : cnt_q;
    sel_d   = tick ? sel_q + 2'd1 : sel_q;
    dead_d  = tick ? DW'(DEAD) : (en && dead_q != '0) ? dead_q - 1'b1 : dead_q;
    frame_d = wrap ? frame_q + 1'b1 : frame_q;
    // anodes stay dark on the select edge and through the dead window to avoid ghosting
    an_d    = (!en || tick || dead_q != '0) ? 4'b1111 : ~lit;
    done_d  = wrap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      dead_q  <= '0;
      frame_q <= '0;
      an_q    <= 4'b1111;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dead_q  <= dead_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      done_q  <= done_d;
    end
  end
  assign sel        = sel_q;
  assign an         = an_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard plus literal scan, blank, blink, freeze and reset sequences
module tb_seg_scan_ctrl;
  localparam int DW = 3, DEAD = 1, BW = 2;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [3:0] digit_en = 4'hF, blink_mask = 4'h0;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_done;
  typedef struct {logic [1:0] sel; logic [3:0] an; logic done;} exp_t;
  typedef struct {logic en; logic [3:0] de; logic [3:0] bm; int n;} vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  int checks = 0, errors = 0;
  logic [DW-1:0] m_cnt;
  logic [1:0]    m_sel;
  logic [BW-1:0] m_frame;
  int            m_dead;

  seg_scan_ctrl #(.DIV_WIDTH(DW), .DEAD(DEAD), .BLINK_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .digit_en(digit_en), .blink_mask(blink_mask),
    .sel(sel), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset;
    m_cnt = '0; m_sel = '0; m_frame = '0; m_dead = 0;
  endtask

  task automatic step;
    exp_t e;
    logic tk;
    tk = en && (m_cnt == '1);
    e.an = (!en || tk || m_dead != 0) ? 4'hF :
           ~((4'b0001 << m_sel) & digit_en & ~(blink_mask & {4{m_frame[BW-1]}}));
    e.done = tk && (m_sel == 2'd3);
    if (en) m_cnt = m_cnt + 1'b1;
    if (tk) begin
      if (m_sel == 2'd3) m_frame = m_frame + 1'b1;
      m_sel = m_sel + 2'd1;
      m_dead = DEAD;
    end else if (en && m_dead > 0) m_dead--;
    e.sel = m_sel;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("sb_sel", 8'(sel), 8'(e.sel));
    chk("sb_an", 8'(an), 8'(e.an));
    chk("sb_frame_done", 8'(frame_done), 8'(e.done));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    chk("rst_async_an", 8'(an), 8'hF);
    chk("rst_async_sel", 8'(sel), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_done, sel_hold;
    int lit_w[5];
    int c_b, c_7, c_e;
    #1 rst = 1'b1;
    #1;
    chk("reset_an", 8'(an), 8'hF);
    chk("reset_sel", 8'(sel), 8'd0);
    chk("reset_frame_done", 8'(frame_done), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    // basic scan order, dead time and frame wrap
    en = 1'b1; digit_en = 4'hF; blink_mask = 4'h0;
    n_done = 0;
    for (int i = 1; i <= 66; i++) begin
      step();
      n_done += int'(frame_done);
      if (i == 1)  chk("scan_first_an", 8'(an), 8'hE);
      if (i == 8)  chk("scan_sel1", 8'(sel), 8'd1);
      if (i == 8)  chk("scan_dead0", 8'(an), 8'hF);
      if (i == 9)  chk("scan_dead1", 8'(an), 8'hF);
      if (i == 10) chk("scan_d1", 8'(an), 8'hD);
      if (i == 18) chk("scan_d2", 8'(an), 8'hB);
      if (i == 26) chk("scan_d3", 8'(an), 8'h7);
      if (i == 32) chk("wrap_done", 8'(frame_done), 8'd1);
      if (i == 32) chk("wrap_sel0", 8'(sel), 8'd0);
      if (i == 33) chk("wrap_done_drop", 8'(frame_done), 8'd0);
      if (i == 34) chk("wrap_d0", 8'(an), 8'hE);
      if (i == 64) chk("wrap2_done", 8'(frame_done), 8'd1);
    end
    chk("done_count", 8'(n_done), 8'd2);
    // freeze mid-slot at cnt=4 of digit 1
    for (int i = 0; i < 10; i++) step();
    en = 1'b0;
    sel_hold = int'(sel);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("freeze_an", 8'(an), 8'hF);
      chk("freeze_sel", 8'(sel), 8'(sel_hold));
    end
    en = 1'b1;
    step();
    chk("resume_no_dead", 8'(an), 8'hD);
    step(); step();
    chk("resume_sel_hold", 8'(sel), 8'd1);
    step();
    chk("resume_tick", 8'(sel), 8'd2);
    // asynchronous reset mid-slot
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("midrst_an", 8'(an), 8'hF);
    chk("midrst_sel", 8'(sel), 8'd0);
    chk("midrst_done", 8'(frame_done), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step();
    chk("midrst_restart", 8'(an), 8'hE);
    // blink: digit 0 lit in frames 0-1, dark in 2-3, lit again in frame 4
    do_reset();
    blink_mask = 4'b0001;
    for (int w = 0; w < 5; w++) lit_w[w] = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (an == 4'hE) lit_w[i / 32]++;
    end
    chk("blink_f0", 8'(lit_w[0]), 8'd7);
    chk("blink_f1", 8'(lit_w[1]), 8'd6);
    chk("blink_f2", 8'(lit_w[2]), 8'd0);
    chk("blink_f3", 8'(lit_w[3]), 8'd0);
    chk("blink_f4", 8'(lit_w[4]), 8'd6);
    // per-digit blanking of digit 2
    do_reset();
    blink_mask = 4'h0; digit_en = 4'b1011;
    c_b = 0; c_7 = 0; c_e = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (an == 4'b1011) c_b++;
      if (an == 4'b0111) c_7++;
      if (an == 4'b1110) c_e++;
    end
    chk("blank_d2", 8'(c_b), 8'd0);
    chk("blank_d3", 8'(c_7), 8'd6);
    chk("blank_d0", 8'(c_e), 8'd7);
    // table-driven mixed patterns against the scoreboard
    tbl.push_back('{1'b1, 4'hF, 4'h0, 20});
    tbl.push_back('{1'b1, 4'b0101, 4'b0110, 70});
    tbl.push_back('{1'b0, 4'hF, 4'hF, 5});
    tbl.push_back('{1'b1, 4'hF, 4'b1010, 100});
    tbl.push_back('{1'b1, 4'h0, 4'h0, 16});
    tbl.push_back('{1'b1, 4'b1110, 4'hF, 60});
    tbl.push_back('{1'b0, 4'b1110, 4'h0, 3});
    tbl.push_back('{1'b1, 4'hF, 4'h1, 40});
    foreach (tbl[k]) begin
      en = tbl[k].en; digit_en = tbl[k].de; blink_mask = tbl[k].bm;
      for (int i = 0; i < tbl[k].n; i++) step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
